mem_rw_arbiter: RTL and testbench
=================================

# mem_rw_arbiter

Two-requester arbiter and sequencer for the shared 8-bit read/write data port of the external memory. Sits between the `mips` core (requester 0) and a second bus master such as a loader or debug port (requester 1) on one side, and the `exmemory` rw port (`rw_addr`, `r`, `w`, `w_en`) on the other. Grants one access per cycle, registers the winning access onto the memory port, and returns read data with a fixed latency.

## Interface
- `AW`, 8, address width (matches `rw_addr`)
- `DW`, 8, data width (matches `r`/`w`)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous reset, active-low (0 = reset)
- `m0_req`  in  1  requester 0 access request; held until granted
- `m0_we`  in  1  requester 0: 1 = write, 0 = read
- `m0_addr`  in  AW  requester 0 address
- `m0_wdata`  in  DW  requester 0 write data
- `m0_gnt`  out  1  requester 0 granted this cycle (combinational)
- `m0_rdata`  out  DW  requester 0 read data
- `m0_rvalid`  out  1  `m0_rdata` valid (1-cycle pulse)
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rdata`, `m1_rvalid`: same as requester 0
- `mem_addr`  out  AW  to memory `rw_addr`
- `mem_w`  out  DW  to memory `w`
- `mem_w_en`  out  1  to memory `w_en`
- `mem_r`  in  DW  from memory `r` (combinational read of `mem_addr`)

## Operation
- Arbitration (cycle A): among requesters with `req`=1, one winner; its `gnt`=1 in the same cycle, the other's `gnt`=0. No request → no grant.
- Round-robin: 1-bit `last` pointer = last granted requester. Both requesting → grant the one ≠ `last`. One requesting → grant it regardless of `last`. `last` updates only on a grant.
- Issue stage (cycle A+1): registered `mem_addr`, `mem_w`, `mem_w_en` (= winner's `we`), plus internal `iss_valid`, `iss_id`, `iss_rd`. No grant in A → `mem_w_en`=0, `iss_valid`=0; `mem_addr`/`mem_w` hold their previous values.
- Return stage (cycle A+2): for a read, `mem_r` sampled at the end of A+1 is registered into `mX_rdata` of the issuing requester; `mX_rvalid`=1 for exactly one cycle. Writes produce no rvalid.
- `mX_rdata` holds its last value until the next read return for that requester.
- A requester may assert `req` again in the cycle after `gnt` (back-to-back); one access per cycle total across both requesters.
- Write-then-read to the same address on consecutive grants returns the new data (write lands at end of A+1, read samples at end of A+2).

## Timing
- Reset (`rst`=0, asynchronous): `mem_w_en`=0, `mem_addr`=0, `mem_w`=0, `m0_rvalid`=`m1_rvalid`=0, `m0_rdata`=`m1_rdata`=0, `iss_valid`=0, `last`=1 (so requester 0 wins the first tie). `mX_gnt`=0 while in reset.
- Reset asserted mid-transaction: in-flight issue and return stages are discarded; no rvalid is produced for them; `mem_w_en` drops immediately, without waiting for a clock edge.
- First rising edge after `rst` deasserts: normal arbitration.
- Grant latency: 0 cycles (combinational). Memory port latency: 1 cycle. Read data latency: 2 cycles from grant.
- Sustained throughput: 1 access/cycle. Under continuous dual request, grants alternate 0,1,0,1…
- No combinational path from `mem_r` to any output.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: requester 0 always wins when both request; the `last` pointer is not implemented; requester 1 is granted only in cycles when `m0_req`=0.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold `rst`=0 with both `req`=1 → all `gnt`, `mem_w_en`, `rvalid` = 0. Release → first tie grants m0.
- Single write: m0 write addr 8'h10, data 8'h5A → `m0_gnt` cycle A; `mem_w_en`=1, `mem_addr`=8'h10, `mem_w`=8'h5A in A+1 only.
- Read return: m1 read addr 8'h10 after the write above → `m1_rvalid`=1, `m1_rdata`=8'h5A at A+2; `m0_rvalid` stays 0.
- Contention: both request reads continuously for 6 cycles → grants m0,m1,m0,m1,m0,m1; each requester sees 3 rvalid pulses with the correct data.
- Async reset mid-read: `rst`=0 asserted between A+1 and A+2 → no rvalid pulse; `mem_w_en`=0 immediately.
- `ARB_FIXED_PRIO_EN` build: both request for 4 cycles → 4 grants to m0, 0 to m1; m0 drops → m1 granted in the same cycle. Write to 8'hFF is seen on `mem_w_en`/`mem_addr`.

Source files
------------

// File: rtl/mem_rw_arbiter.sv
// Two-requester arbiter and sequencer onto the shared memory rw port: gnt is combinational, the port is registered (1 cycle), read data returns 2 cycles after gnt.
// Requesters hold req until gnt, which is the only backpressure. Define ARB_FIXED_PRIO_EN to make requester 0 always win ties (round-robin otherwise).
module mem_rw_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_w,
   output logic          mem_w_en,
   input  logic [DW-1:0] mem_r
);

   logic          win0;
   logic          win1;
   logic          any_gnt;
   logic          win_we;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   logic          iss_valid;
   logic          iss_id;
   logic          iss_rd;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      win0 = m0_req;
      win1 = m1_req & ~m0_req;
   end
`else
   // last = 1 means requester 1 was granted most recently, so 0 wins the next tie
   logic last;

   always_comb begin
      win0 = m0_req & (~m1_req | last);
      win1 = m1_req & (~m0_req | ~last);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (win0 | win1) begin
         last <= win1;
      end
   end
`endif

   // Grants are forced low while reset is held, independent of the clock
   assign m0_gnt  = rst & win0;
   assign m1_gnt  = rst & win1;
   assign any_gnt = m0_gnt | m1_gnt;

   always_comb begin
      win_we    = m0_we;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
      if (m1_gnt) begin
         win_we    = m1_we;
         win_addr  = m1_addr;
         win_wdata = m1_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss_valid <= 1'b0;
         iss_id    <= 1'b0;
         iss_rd    <= 1'b0;
         mem_w_en  <= 1'b0;
         mem_addr  <= '0;
         mem_w     <= '0;
      end else begin
         iss_valid <= any_gnt;
         iss_rd    <= any_gnt & ~win_we;
         mem_w_en  <= any_gnt & win_we;
         if (any_gnt) begin
            iss_id   <= m1_gnt;
            mem_addr <= win_addr;
            mem_w    <= win_wdata;
         end
      end
   end

   // Read data is captured from the port a cycle after issue and steered back by iss_id
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= iss_valid & iss_rd & ~iss_id;
         m1_rvalid <= iss_valid & iss_rd & iss_id;
         if (iss_valid && iss_rd && !iss_id) begin
            m0_rdata <= mem_r;
         end
         if (iss_valid && iss_rd && iss_id) begin
            m1_rdata <= mem_r;
         end
      end
   end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed table of per-cycle vectors against a behavioural memory, plus hand-written async reset sequences.
module tb_mem_rw_arbiter;

   logic       clk;
   logic       rst;
   logic       m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [7:0] m0_addr, m0_wdata, m0_rdata;
   logic       m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [7:0] m1_addr, m1_wdata, m1_rdata;
   logic [7:0] mem_addr, mem_w, mem_r;
   logic       mem_w_en;

   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;
   int row    = 0;

   mem_rw_arbiter #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .mem_addr(mem_addr), .mem_w(mem_w), .mem_w_en(mem_w_en), .mem_r(mem_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: combinational read, write on the rising edge when w_en is high
   assign mem_r = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_w_en) mem[mem_addr] <= mem_w;
   end

   typedef struct {
      logic       rst;
      logic       r0, w0;
      logic [7:0] a0, d0;
      logic       r1, w1;
      logic [7:0] a1, d1;
      logic       g0, g1, wen;
      logic [7:0] maddr, mw;
      logic       v0;
      logic [7:0] rd0;
      logic       v1;
      logic [7:0] rd1;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic rs,
      input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
      input logic g0, input logic g1, input logic wen, input logic [7:0] maddr, input logic [7:0] mw,
      input logic v0, input logic [7:0] rd0, input logic v1, input logic [7:0] rd1);
      vec_t v;
      v.rst = rs;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.wen = wen; v.maddr = maddr; v.mw = mw;
      v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d actual %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rst = v.rst;
      m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
   endtask

   task automatic check_vec(input vec_t v);
      chk("m0_gnt",    {7'd0, m0_gnt},    {7'd0, v.g0});
      chk("m1_gnt",    {7'd0, m1_gnt},    {7'd0, v.g1});
      chk("mem_w_en",  {7'd0, mem_w_en},  {7'd0, v.wen});
      chk("mem_addr",  mem_addr,          v.maddr);
      chk("mem_w",     mem_w,             v.mw);
      chk("m0_rvalid", {7'd0, m0_rvalid}, {7'd0, v.v0});
      chk("m0_rdata",  m0_rdata,          v.rd0);
      chk("m1_rvalid", {7'd0, m1_rvalid}, {7'd0, v.v1});
      chk("m1_rdata",  m1_rdata,          v.rd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

      // rst r0 w0 a0 d0 | r1 w1 a1 d1 || g0 g1 wen maddr mw | v0 rd0 v1 rd1
      vecs[0]  = mk(0, 1,0,8'h20,8'h00, 1,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00,0,8'h00);
      vecs[1]  = mk(0, 1,0,8'h20,8'h00, 1,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00,0,8'h00);
      vecs[2]  = mk(1, 1,1,8'h10,8'h5A, 1,0,8'h10,8'h00, 1,0,0,8'h00,8'h00, 0,8'h00,0,8'h00);
      vecs[3]  = mk(1, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1,1,8'h10,8'h5A, 0,8'h00,0,8'h00);
      vecs[4]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'h00, 0,8'h00,0,8'h00);
      vecs[5]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'h00, 0,8'h00,1,8'h5A);
`ifdef ARB_FIXED_PRIO_EN
      vecs[6]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h10,8'h00, 0,8'h00,0,8'h5A);
      vecs[7]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h20,8'h11, 0,8'h00,0,8'h5A);
      vecs[8]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h20,8'h11, 1,8'hDF,0,8'h5A);
      vecs[9]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h20,8'h11, 1,8'hDF,0,8'h5A);
      vecs[10] = mk(1, 0,0,8'h20,8'h11, 1,0,8'h21,8'h22, 0,1,0,8'h20,8'h11, 1,8'hDF,0,8'h5A);
      vecs[11] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h21,8'h22, 1,8'hDF,0,8'h5A);
      vecs[12] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h21,8'h22, 0,8'hDF,1,8'hDE);
      vecs[13] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h21,8'h22, 0,8'hDF,0,8'hDE);
`else
      vecs[6]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h10,8'h00, 0,8'h00,0,8'h5A);
      vecs[7]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 0,1,0,8'h20,8'h11, 0,8'h00,0,8'h5A);
      vecs[8]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h21,8'h22, 1,8'hDF,0,8'h5A);
      vecs[9]  = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 0,1,0,8'h20,8'h11, 0,8'hDF,1,8'hDE);
      vecs[10] = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 1,0,0,8'h21,8'h22, 1,8'hDF,0,8'hDE);
      vecs[11] = mk(1, 1,0,8'h20,8'h11, 1,0,8'h21,8'h22, 0,1,0,8'h20,8'h11, 0,8'hDF,1,8'hDE);
      vecs[12] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h21,8'h22, 1,8'hDF,0,8'hDE);
      vecs[13] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h21,8'h22, 0,8'hDF,1,8'hDE);
`endif
      vecs[14] = mk(1, 0,0,8'h00,8'h00, 1,1,8'h40,8'h77, 0,1,0,8'h21,8'h22, 0,8'hDF,0,8'hDE);
      vecs[15] = mk(1, 1,0,8'h40,8'h33, 0,0,8'h00,8'h00, 1,0,1,8'h40,8'h77, 0,8'hDF,0,8'hDE);
      vecs[16] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h40,8'h33, 0,8'hDF,0,8'hDE);
      vecs[17] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h40,8'h33, 1,8'h77,0,8'hDE);
      vecs[18] = mk(1, 1,1,8'hFF,8'hC3, 0,0,8'h00,8'h00, 1,0,0,8'h40,8'h33, 0,8'h77,0,8'hDE);
      vecs[19] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,1,8'hFF,8'hC3, 0,8'h77,0,8'hDE);
      vecs[20] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'hFF,8'hC3, 0,8'h77,0,8'hDE);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         #1;
         row = i;
         check_vec(vecs[i]);
      end
      chk("mem_ff_written", mem[8'hFF], 8'hC3);

      // Reset lands while a write is on the port and a read has just been granted
      row = 100;
      @(posedge clk); #1;
      m1_req = 1; m1_we = 1; m1_addr = 8'h60; m1_wdata = 8'h44;
      #1;
      chk("rs_m1_gnt", {7'd0, m1_gnt}, 8'd1);
      @(posedge clk); #1;
      m1_req = 0; m1_we = 0;
      m0_req = 1; m0_we = 0; m0_addr = 8'h20;
      #1;
      chk("rs_m0_gnt", {7'd0, m0_gnt}, 8'd1);
      chk("rs_wen_pre", {7'd0, mem_w_en}, 8'd1);
      chk("rs_addr_pre", mem_addr, 8'h60);
      #1;
      rst = 0;
      #1;
      chk("rs_wen_async", {7'd0, mem_w_en}, 8'd0);
      chk("rs_gnt_in_rst", {7'd0, m0_gnt}, 8'd0);
      chk("rs_addr_async", mem_addr, 8'h00);
      for (int k = 0; k < 3; k++) begin
         row = 101 + k;
         @(posedge clk); #2;
         chk("rs_m0_rvalid", {7'd0, m0_rvalid}, 8'd0);
         chk("rs_m1_rvalid", {7'd0, m1_rvalid}, 8'd0);
         chk("rs_m0_rdata", m0_rdata, 8'h00);
         chk("rs_m1_rdata", m1_rdata, 8'h00);
         chk("rs_wen_held", {7'd0, mem_w_en}, 8'd0);
         chk("rs_gnt_held", {7'd0, m0_gnt}, 8'd0);
      end
      chk("rs_no_write", mem[8'h60], 8'h9F);

      // Release with both requesting: requester 0 must win the first tie
      row = 110;
      @(posedge clk); #1;
      rst = 1;
      m0_req = 1; m0_we = 0; m0_addr = 8'h20;
      m1_req = 1; m1_we = 0; m1_addr = 8'h21;
      #1;
      chk("rel_m0_gnt", {7'd0, m0_gnt}, 8'd1);
      chk("rel_m1_gnt", {7'd0, m1_gnt}, 8'd0);

      // Reset between issue and return of that read: no rvalid may follow
      @(posedge clk); #1;
      m0_req = 0; m1_req = 0;
      #1;
      chk("rr_addr", mem_addr, 8'h20);
      chk("rr_wen", {7'd0, mem_w_en}, 8'd0);
      #1;
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         row = 111 + k;
         @(posedge clk); #2;
         chk("rr_m0_rvalid", {7'd0, m0_rvalid}, 8'd0);
         chk("rr_m0_rdata", m0_rdata, 8'h00);
      end
      @(posedge clk); #1;
      rst = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
